serial_add_rx: RTL and testbench

Word-level receiving end of a bit-serial add stream. Accepts one operand bit pair per handshake, LSB first, with a per-word carry-in and a start-of-word marker. Accumulates a running ripple sum with a registered carry, deserialises the sum bits into a `WIDTH`-bit word, and presents the word plus carry-out on a valid/ready output. Sits downstream of bit-serial adder test logic as the collector that turns per-bit sum/carry traffic back into words.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/full_add_bit.sv | 13 +
 rtl/serial_add_rx.sv | 112 +++++++++++
 tb/tb_serial_add_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial add receiver: FSM state codes and legal WIDTH bounds.
package serial_add_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_HOLD    = 2'd2;

endpackage

// File: rtl/full_add_bit.sv
// One-bit combinational full adder.
module full_add_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_rx.sv
// Collects LSB-first operand bit pairs, ripples them through one full adder with a
// registered carry, and presents the deserialised sum word plus carry-out on valid/ready.
module serial_add_rx
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_add_rx: WIDTH out of range");
    end

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    logic               carry;
    logic [WIDTH-1:0]   sum;

    logic               accept;
    logic               restart;
    logic               extend;
    logic               last_bit;
    logic               fa_ci;
    logic               fa_s;
    logic               fa_co;

    assign in_ready  = (state != ST_HOLD);
    assign out_sum   = sum;
    assign out_cout  = carry;

    // Handshake decode; a first-marked pair always restarts, even mid-word.
    always_comb begin
        accept   = in_valid && in_ready;
        restart  = accept && in_first;
        extend   = accept && !in_first && (state == ST_COLLECT);
        last_bit = extend && (count == CNT_W'(WIDTH - 1));
        fa_ci    = restart ? in_cin : carry;
    end

    full_add_bit u_fa (
        .a  (in_a),
        .b  (in_b),
        .ci (fa_ci),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (restart) next_state = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (last_bit) next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath: carry, bit count and right-shifting sum register, plus registered status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry     <= 1'b0;
            count     <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_err   <= accept && !in_first && (state == ST_IDLE);
            out_valid <= (next_state == ST_HOLD);
            if (restart) begin
                carry <= fa_co;
                count <= CNT_W'(1);
                sum   <= {fa_s, {(WIDTH-1){1'b0}}};
            end else if (extend) begin
                carry <= fa_co;
                sum   <= {fa_s, sum[WIDTH-1:1]};
                // Wrap to zero on the final bit so the count stays within WIDTH-1.
                count <= last_bit ? '0 : count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_rx.sv
// Self-checking bench for serial_add_rx: directed scenarios plus randomized words
// checked against an arithmetic reference (A + B + cin).
module tb_serial_add_rx;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic         in_a;
    logic         in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_err;

    int errors = 0;
    int checks = 0;

    logic [W:0] exp_word;

    always #5 clk = ~clk;

    serial_add_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pair for a single cycle; acc reports whether it was handshaken.
    task automatic drive_pair(input logic f, input logic a, input logic b, input logic c,
                              output bit acc);
        in_valid = 1'b1;
        in_first = f;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        acc      = (in_ready === 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                             input int max_gap);
        bit acc;
        exp_word = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        for (int i = 0; i < int'(W); i++) begin
            repeat ($urandom_range(0, max_gap)) step();
            drive_pair(i == 0, a[i], b[i], (i == 0) ? c : 1'($urandom), acc);
            check("bit_accept", 64'(acc), 1);
            check("err_quiet", 64'(out_err), 0);
            if (i < int'(W) - 1) check("valid_early", 64'(out_valid), 0);
        end
        check("valid_rise", 64'(out_valid), 1);
        check("sum", 64'(out_sum), 64'(exp_word[W-1:0]));
        check("cout", 64'(out_cout), 64'(exp_word[W]));
    endtask

    task automatic stray();
        bit acc;
        drive_pair(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), acc);
        check("stray_accept", 64'(acc), 1);
        check("err_pulse", 64'(out_err), 1);
        step();
        check("err_single", 64'(out_err), 0);
    endtask

    // Hold the word for `hold` cycles, then release; optionally probe the release cycle.
    task automatic release_word(input int hold, input bit probe);
        out_ready = 1'b0;
        repeat (hold) begin
            step();
            check("hold_valid", 64'(out_valid), 1);
            check("hold_ready", 64'(in_ready), 0);
            check("hold_sum", 64'(out_sum), 64'(exp_word[W-1:0]));
            check("hold_cout", 64'(out_cout), 64'(exp_word[W]));
        end
        out_ready = 1'b1;
        if (probe) begin
            in_valid = 1'b1;
            in_first = 1'b1;
            in_a     = 1'b1;
            in_b     = 1'b1;
            in_cin   = 1'b1;
            check("release_not_ready", 64'(in_ready), 0);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 0);
        check("release_ready", 64'(in_ready), 1);
        // A stray now must be flagged, proving the release-cycle pair left us in IDLE.
        if (probe) stray();
    endtask

    task automatic partial(input int k);
        bit acc;
        for (int i = 0; i < k; i++) begin
            drive_pair(i == 0, 1'($urandom), 1'($urandom), 1'($urandom), acc);
            check("partial_accept", 64'(acc), 1);
            check("partial_err", 64'(out_err), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 1);
        check({tag, "_out_valid"}, 64'(out_valid), 0);
        check({tag, "_out_sum"}, 64'(out_sum), 0);
        check({tag, "_out_cout"}, 64'(out_cout), 0);
        check({tag, "_out_err"}, 64'(out_err), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_a      = 1'b0;
        in_b      = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        send_word(8'h3C, 8'h5A, 1'b0, 0);
        release_word(0, 1'b0);
        send_word(8'hFF, 8'h01, 1'b0, 0);
        release_word(0, 1'b0);
        send_word(8'hFF, 8'h00, 1'b1, 0);
        release_word(1, 1'b0);

        // Backpressure with a pair offered in the release cycle.
        send_word(8'hA5, 8'h7E, 1'b1, 0);
        release_word(5, 1'b1);

        // Abort after three bits; the restart must not raise an error.
        partial(3);
        send_word(8'h01, 8'h01, 1'b0, 0);
        release_word(0, 1'b0);

        stray();
        send_word(8'h81, 8'h7F, 1'b0, 1);
        release_word(2, 1'b0);

        // Asynchronous reset mid-word.
        partial(4);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        step();
        rst = 1'b0;
        check_reset_outputs("post_rst");
        send_word(8'h12, 8'h34, 1'b1, 0);
        release_word(0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 3) == 0) stray();
            if ($urandom_range(0, 4) == 0) partial(int'($urandom_range(1, W - 1)));
            send_word(a, b, 1'($urandom), ($urandom_range(0, 1) == 0) ? 0 : 2);
            release_word(int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
